sbox_layer_ctrl: RTL and testbench
==================================

# sbox_layer_ctrl

Sequencer for the Ascon substitution layer. It applies the 5-bit Ascon S-box to all 64 bit-columns of the 320-bit permutation state, using a parameterised number of shared `sbox` instances over several cycles. It sits between the permutation round controller and the `sbox` datapath, and trades area against latency through `NB_SBOX`.

## Interface
Parameters:
- `NB_SBOX`, default 8: number of `sbox` instances, i.e. columns processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64.
- `NB_STEP`: derived as 64/`NB_SBOX`. It is the number of RUN cycles and cannot be overridden.

Ports:
- `clock_i` in, 1: single clock, rising-edge.
- `reset_i` in, 1: **synchronous, active-high** reset.
- `start_i` in, 1: request to substitute `state_i`. Sampled only in IDLE.
- `state_i` in, 320: input state. Layout is x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0].
- `state_o` out, 320: working/result register, same layout as `state_i`.
- `busy_o` out, 1: high in RUN and DONE.
- `done_o` out, 1: one-cycle pulse; `state_o` is the final result while it is high.

## Operation
- **Column j** (0..63):
  - S-box input is {x0[j], x1[j], x2[j], x3[j], x4[j]}, with x0 as the MSB.
  - The output bits are written back to x0[j]..x4[j] in the same order.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE: when `start_i`=1, load `state_i` into the working register, clear the step counter `cnt`, and go to RUN. Otherwise stay in IDLE and hold the register.
  - RUN: on each cycle, process columns cnt·NB_SBOX through cnt·NB_SBOX+NB_SBOX−1 and write the results into the register.
    - Columns outside that slice are unchanged.
    - `cnt` increments by 1.
    - When cnt = NB_STEP−1, write the slice and go to DONE.
  - DONE: assert `done_o` for exactly one cycle, then return to IDLE. The register holds its value.
- **Step counter:** width is max(1, log2(NB_STEP)). It never wraps during a run, because the exit at NB_STEP−1 is mandatory.
  - For NB_SBOX=64 there is a single RUN cycle with cnt=0.
- **Ignored inputs:** `start_i` is ignored in RUN and DONE. `state_i` is only read in the IDLE load cycle.
- **Result holding:** the result stays on `state_o` after DONE until the next accepted `start_i`.
- **`sbox` instances:** purely combinational. There are no additional pipeline registers.

## Timing
- **Reset values:** FSM=IDLE, cnt=0, `state_o`=0, `busy_o`=0, `done_o`=0.
- **Latency:** with `start_i` sampled high at edge E0, RUN covers edges E1..E_NB_STEP and `done_o` is high in the cycle after edge E_NB_STEP.
  - NB_SBOX=8: `done_o` is high in the 9th cycle after the start cycle.
  - NB_SBOX=64: `done_o` is high in the cycle after the single RUN cycle.
- **`busy_o`:** rises in the cycle after start is accepted and falls in the cycle after `done_o`.
- **Back-to-back:** `start_i` held high continuously is accepted again on the first IDLE cycle after DONE. The minimum period is NB_STEP+2 cycles.
- **Intermediate values:** during RUN, `state_o` is partially substituted and must not be consumed.
- **Reset mid-run:** `reset_i` in RUN or DONE aborts the run. It forces all outputs to reset values at the next edge and produces no `done_o` pulse.
- **Reset with start:** `reset_i` and `start_i` high in the same cycle → reset wins and start is dropped.

## Test plan
- **All-zero input:** reset, then `start_i` with `state_i`=0 (NB_SBOX=8) → `done_o` 9 cycles later; `state_o` has x2=64'hFFFF_FFFF_FFFF_FFFF and x0, x1, x3, x4 all zero (S(0)=04).
- **All-ones input:** `state_i` all ones → x0, x2, x3, x4 all ones and x1=0 (S(1F)=17).
- **Single-column input:** x4=64'h1, others 0 → x1=64'h1, x3=64'h1, x4=64'h1 and x2=all ones except bit 0 (S(01)=0B).
- **Slice ordering:** random state with NB_SBOX ∈ {1, 8, 64} → compare against a golden full-table model. Also check that after RUN step k only columns < (k+1)·NB_SBOX differ from the input, and check the done latency for each value.
- **Start while busy:** pulse `start_i` with a different `state_i` during RUN → ignored and the result is unchanged. `start_i` held high → second run begins exactly one cycle after `done_o`.
- **Reset mid-run:** `reset_i` at RUN step 3 → next cycle `state_o`=0, `busy_o`=0, no `done_o`. A new start then completes normally.

Source files
------------

// File: rtl/sbox_layer_ctrl.sv
// Ascon substitution-layer sequencer: applies the 5-bit S-box to all 64 state
// columns, NB_SBOX columns per cycle, over 64/NB_SBOX RUN cycles.

module sbox (
  input  logic [4:0] x,
  output logic [4:0] y
);
  always_comb begin
    y = 5'h00;
    case (x)
      5'h00: y = 5'h04; 5'h01: y = 5'h0b; 5'h02: y = 5'h1f; 5'h03: y = 5'h14;
      5'h04: y = 5'h1a; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
      5'h08: y = 5'h1b; 5'h09: y = 5'h05; 5'h0a: y = 5'h08; 5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d; 5'h0d: y = 5'h03; 5'h0e: y = 5'h06; 5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0e;
      5'h14: y = 5'h00; 5'h15: y = 5'h0d; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
      5'h18: y = 5'h10; 5'h19: y = 5'h0c; 5'h1a: y = 5'h01; 5'h1b: y = 5'h19;
      5'h1c: y = 5'h16; 5'h1d: y = 5'h0a; 5'h1e: y = 5'h0f; 5'h1f: y = 5'h17;
      default: y = 5'h00;
    endcase
  end
endmodule

module sbox_layer_ctrl #(
  parameter int NB_SBOX = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam int NB_STEP = 64 / NB_SBOX;
  localparam int CW      = (NB_STEP > 1) ? $clog2(NB_STEP) : 1;
  localparam int LG      = $clog2(NB_SBOX);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t               fsm, fsm_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  // word 4 is x0 (bits 319:256), word 0 is x4 (bits 63:0)
  logic [4:0][63:0]   st, st_nxt, st_sub;
  logic [5:0]         base;
  logic [NB_SBOX-1:0][4:0] sin, sout;

  assign base = 6'(cnt) << LG;

  always_comb begin
    for (int i = 0; i < NB_SBOX; i++)
      for (int w = 0; w < 5; w++)
        sin[i][w] = st[w][base + 6'(i)];
  end

  for (genvar g = 0; g < NB_SBOX; g++) begin : g_lane
    sbox u_sbox (.x(sin[g]), .y(sout[g]));
  end

  always_comb begin
    st_sub = st;
    for (int i = 0; i < NB_SBOX; i++)
      for (int w = 0; w < 5; w++)
        st_sub[w][base + 6'(i)] = sout[i][w];
  end

  always_comb begin
    fsm_nxt = fsm;
    cnt_nxt = cnt;
    st_nxt  = st;
    case (fsm)
      IDLE: if (start_i) begin
        st_nxt  = state_i;
        cnt_nxt = '0;
        fsm_nxt = RUN;
      end
      RUN: begin
        st_nxt = st_sub;
        // counter holds on the last step so it can never wrap
        if (cnt == CW'(NB_STEP - 1)) fsm_nxt = DONE;
        else                         cnt_nxt = cnt + CW'(1);
      end
      DONE:    fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm <= IDLE;
      cnt <= '0;
      st  <= '0;
    end else begin
      fsm <= fsm_nxt;
      cnt <= cnt_nxt;
      st  <= st_nxt;
    end
  end

  assign state_o = st;
  assign busy_o  = (fsm != IDLE);
  assign done_o  = (fsm == DONE);
endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Directed bench for sbox_layer_ctrl: NB_SBOX = 1, 8 and 64 instances share
// the stimulus; most checks target the 8-lane instance.

module tb_sbox_layer_ctrl;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [319:0] sin;
  logic [319:0] so1, so8, so64;
  logic         b1, b8, b64, d1, d8, d64;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] SBOX_T [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  localparam logic [63:0] Z = 64'h0;
  localparam logic [63:0] O = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  sbox_layer_ctrl #(.NB_SBOX(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .state_i(sin),
    .state_o(so1), .busy_o(b1), .done_o(d1));
  sbox_layer_ctrl #(.NB_SBOX(8)) dut8 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .state_i(sin),
    .state_o(so8), .busy_o(b8), .done_o(d8));
  sbox_layer_ctrl #(.NB_SBOX(64)) dut64 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .state_i(sin),
    .state_o(so64), .busy_o(b64), .done_o(d64));

  // columns below ncols substituted, the rest copied from s
  function automatic logic [319:0] subst(input logic [319:0] s, input int ncols);
    logic [319:0] r;
    logic [4:0]   c, o;
    r = s;
    for (int j = 0; j < ncols; j++) begin
      c = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
      o = SBOX_T[c];
      {r[256+j], r[192+j], r[128+j], r[64+j], r[j]} = o;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // start dut8 with v, return cycles from the start edge to done and the result
  task automatic run8(input logic [319:0] v, output int lat, output logic [319:0] res);
    int n;
    sin = v; start = 1'b1;
    step;
    start = 1'b0;
    n = 1;
    while (!d8 && n < 30) begin step; n++; end
    lat = d8 ? n : -1;
    res = so8;
  endtask

  initial begin
    logic [319:0] ra, rb, rc, f1, f64;
    int n, l1, l8, l64, lat, nodone;
    logic [319:0] res;

    rst = 1'b1; start = 1'b0; sin = '0;
    step; step;
    rst = 1'b0;
    chk("reset_state", so8, '0);
    chk("reset_busy", 320'(b8), 320'(0));
    chk("reset_done", 320'(d8), 320'(0));

    // golden model comparison across 1/8/64 lanes, with slice ordering on 8 lanes
    ra = rnd320();
    sin = ra; start = 1'b1;
    step;
    start = 1'b0;
    n = 1; l1 = 0; l8 = 0; l64 = 0; f1 = '0; f64 = '0;
    chk("load_state", so8, ra);
    while (!(l1 != 0 && l8 != 0 && l64 != 0) && n < 100) begin
      step; n++;
      if (n >= 2 && n <= 9) chk($sformatf("slice_n%0d", n), so8, subst(ra, (n - 1) * 8));
      if (d1  && l1  == 0) begin l1  = n; f1  = so1;  end
      if (d8  && l8  == 0) l8 = n;
      if (d64 && l64 == 0) begin l64 = n; f64 = so64; end
    end
    chk("lat_nb1", 320'(l1), 320'(65));
    chk("lat_nb8", 320'(l8), 320'(9));
    chk("lat_nb64", 320'(l64), 320'(2));
    chk("gold_nb1", f1, subst(ra, 64));
    chk("gold_nb64", f64, subst(ra, 64));
    chk("hold_nb64", so64, subst(ra, 64));
    step;
    chk("busy_fall", 320'(b8), 320'(0));
    chk("hold_nb8", so8, subst(ra, 64));

    // hand-computed vectors
    run8('0, lat, res);
    chk("zero_lat", 320'(lat), 320'(9));
    chk("zero_res", res, {Z, Z, O, Z, Z});
    chk("done_busy", 320'(b8), 320'(1));
    step;
    run8({5{O}}, lat, res);
    chk("ones_res", res, {O, Z, O, O, O});
    step;
    run8({Z, Z, Z, Z, 64'h1}, lat, res);
    chk("col0_res", res, {Z, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1});
    step;

    // start pulse during RUN is ignored
    ra = rnd320(); rb = rnd320();
    sin = ra; start = 1'b1;
    step;
    start = 1'b0; n = 1;
    step; step; n = 3;
    sin = rb; start = 1'b1;
    step; n++;
    start = 1'b0;
    while (!d8 && n < 30) begin step; n++; end
    chk("ign_lat", 320'(n), 320'(9));
    chk("ign_res", so8, subst(ra, 64));
    step;

    // start held high: restart one cycle after done
    ra = rnd320(); rb = rnd320();
    run8(ra, lat, res);
    start = 1'b1;
    chk("held_res", res, subst(ra, 64));
    sin = rb;
    step;
    chk("held_idle_busy", 320'(b8), 320'(0));
    step;
    chk("held_restart_busy", 320'(b8), 320'(1));
    chk("held_restart_load", so8, rb);
    start = 1'b0; n = 1;
    while (!d8 && n < 30) begin step; n++; end
    chk("held_lat", 320'(n), 320'(9));
    chk("held_res2", so8, subst(rb, 64));
    step;

    // reset during RUN step 3
    ra = rnd320();
    sin = ra; start = 1'b1;
    step;
    start = 1'b0;
    step; step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_state", so8, '0);
    chk("mid_rst_busy", 320'(b8), 320'(0));
    nodone = 0;
    for (int k = 0; k < 12; k++) begin
      if (d8) nodone++;
      step;
    end
    chk("mid_rst_nodone", 320'(nodone), 320'(0));

    // reset and start together: reset wins
    rc = rnd320();
    sin = rc; rst = 1'b1; start = 1'b1;
    step;
    rst = 1'b0; start = 1'b0;
    step;
    chk("rst_start_busy", 320'(b8), 320'(0));
    chk("rst_start_state", so8, '0);

    run8(rc, lat, res);
    chk("post_rst_lat", 320'(lat), 320'(9));
    chk("post_rst_res", res, subst(rc, 64));
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
